// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch/execute slice:
// FU identifiers, implemented mask and result-queue entry.
package dispatch_pkg;

  localparam int NUM_FU = 8;
  localparam int FU_ADD = 0;
  localparam int FU_SUB = 1;
  localparam int FU_AND = 2;
  localparam int FU_OR  = 3;
  localparam int FU_XOR = 4;
  localparam int FU_SLL = 5;
  localparam int FU_SRL = 6;
  localparam int FU_MUL = 7;

  localparam int RQ_DATA_W = 32;
  localparam int RQ_TAG_W  = 4;

  localparam logic [NUM_FU-1:0] FU_IMPL = '1;

  typedef struct packed {
    logic [RQ_TAG_W-1:0]  tag;
    logic [RQ_DATA_W-1:0] data;
  } rq_entry_t;

endpackage

// File: rtl/result_queue.sv
// First-word-fall-through result FIFO with wrap-around
// pointers; the head is zero while the queue is empty.
import dispatch_pkg::*;

module result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rq_entry_t                  wr,
  input  logic                       pop,
  output rq_entry_t                  rd,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rq_entry_t         mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd      = empty ? '0 : mem[rptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dispatch_execute_unit.sv
// Dispatch consumer, eight FUs, lowest-ID completion
// arbiter and the held broadcast bus towards the ROB.
import dispatch_pkg::*;

module dispatch_execute_unit #(
  parameter int DATA_WIDTH  = RQ_DATA_W,
  parameter int TAG_WIDTH   = RQ_TAG_W,
  parameter int EXEC_WIDTH  = 4,
  parameter int MUL_LATENCY = 4,
  parameter int RQ_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     dispatch,
  input  logic [DATA_WIDTH-1:0]    op1,
  input  logic [DATA_WIDTH-1:0]    op2,
  input  logic [EXEC_WIDTH-1:0]    executionID_DU,
  input  logic [TAG_WIDTH-1:0]     executionTag,
  output logic [2**EXEC_WIDTH-1:0] availableFunctionalUnits,
  output logic                     broadcastDataAvailable,
  output logic [TAG_WIDTH-1:0]     broadcastDestinationTag,
  output logic [DATA_WIDTH-1:0]    broadcastDestinationData,
  input  logic                     ongoingBroadcast,
  output logic                     dispatchError
);

  localparam int FW  = $clog2(NUM_FU);
  localparam int MCW = $clog2(MUL_LATENCY);
  localparam int QCW = $clog2(RQ_DEPTH) + 1;

  logic [NUM_FU-1:0]     busy;
  logic [NUM_FU-1:0]     accept;
  logic [NUM_FU-1:0]     done;
  logic [NUM_FU-1:0]     grant;
  logic [DATA_WIDTH-1:0] a_q [NUM_FU];
  logic [DATA_WIDTH-1:0] b_q [NUM_FU];
  logic [TAG_WIDTH-1:0]  t_q [NUM_FU];
  logic [DATA_WIDTH-1:0] res [NUM_FU];
  logic [MCW-1:0]        mul_cnt;
  logic [FW-1:0]         win;
  logic                  any_done;
  logic                  bad;
  logic                  push;
  logic                  pop;
  rq_entry_t             wr;
  rq_entry_t             head;
  logic                  q_full;
  logic                  q_empty;
  logic [QCW-1:0]        q_count;

  // Per-FU accept decode and the idle mask seen by the ROB.
  always_comb begin
    accept = '0;
    availableFunctionalUnits = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      accept[i] = dispatch & ~halt & FU_IMPL[i] & ~busy[i]
                & (executionID_DU == EXEC_WIDTH'(i));
      availableFunctionalUnits[i] = FU_IMPL[i] & ~busy[i]
        & ~(dispatch & (executionID_DU == EXEC_WIDTH'(i)));
    end
  end

  assign bad = dispatch & ~halt & ~|accept;

  // FU datapaths operate on their latched operands.
  always_comb begin
    res[FU_ADD] = a_q[FU_ADD] + b_q[FU_ADD];
    res[FU_SUB] = a_q[FU_SUB] - b_q[FU_SUB];
    res[FU_AND] = a_q[FU_AND] & b_q[FU_AND];
    res[FU_OR]  = a_q[FU_OR]  | b_q[FU_OR];
    res[FU_XOR] = a_q[FU_XOR] ^ b_q[FU_XOR];
    res[FU_SLL] = a_q[FU_SLL] << b_q[FU_SLL][4:0];
    res[FU_SRL] = a_q[FU_SRL] >> b_q[FU_SRL][4:0];
    res[FU_MUL] = a_q[FU_MUL] * b_q[FU_MUL];
  end

  // Completion: single-cycle FUs are done once busy, mul on count 0.
  always_comb begin
    done = busy;
    done[FU_MUL] = busy[FU_MUL] & (mul_cnt == '0);
    any_done = |done;
    win = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (done[i]) win = FW'(i);
    end
  end

  assign pop   = ~q_empty & ~ongoingBroadcast & ~halt;
  assign push  = any_done & ~halt
               & ((q_count < QCW'(RQ_DEPTH)) | pop);
  assign grant = push ? (NUM_FU'(1) << win) : '0;
  assign wr    = '{tag: t_q[win], data: res[win]};

  // Operand capture needs no reset; busy qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        a_q[i] <= op1;
        b_q[i] <= op2;
        t_q[i] <= executionTag;
      end
    end
  end

  // Busy flags, multiplier countdown and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      mul_cnt       <= '0;
      dispatchError <= 1'b0;
    end else if (!halt) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i])     busy[i] <= 1'b1;
        else if (grant[i]) busy[i] <= 1'b0;
      end
      if (accept[FU_MUL])
        mul_cnt <= MCW'(MUL_LATENCY - 1);
      else if (busy[FU_MUL] && mul_cnt != '0)
        mul_cnt <= mul_cnt - 1'b1;
      if (bad) dispatchError <= 1'b1;
    end
  end

  result_queue #(.DEPTH(RQ_DEPTH)) u_rq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wr    (wr),
    .pop   (pop),
    .rd    (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign broadcastDataAvailable   = ~q_empty;
  assign broadcastDestinationTag  = head.tag;
  assign broadcastDestinationData = head.data;

  // Occupancy count and full flag must always agree.
  always @(posedge clk) begin
    if (!rst) assert (q_full == (q_count == QCW'(RQ_DEPTH)));
  end

endmodule

// File: tb/tb_dispatch_execute_unit.sv
// Directed bench for dispatch_execute_unit: per-FU vector
// table plus hold, queue-full, error and reset sequences.
module tb_dispatch_execute_unit;

  logic        clk = 0;
  logic        rst = 1;
  logic        halt = 0;
  logic        dispatch = 0;
  logic [31:0] op1 = 0;
  logic [31:0] op2 = 0;
  logic [3:0]  eid = 0;
  logic [3:0]  etag = 0;
  logic [15:0] avail;
  logic        bda;
  logic [3:0]  btag;
  logic [31:0] bdata;
  logic        ongoing = 0;
  logic        err;

  int tests = 0;
  int fails = 0;

  dispatch_execute_unit dut (
    .clk                      (clk),
    .rst                      (rst),
    .halt                     (halt),
    .dispatch                 (dispatch),
    .op1                      (op1),
    .op2                      (op2),
    .executionID_DU           (eid),
    .executionTag             (etag),
    .availableFunctionalUnits (avail),
    .broadcastDataAvailable   (bda),
    .broadcastDestinationTag  (btag),
    .broadcastDestinationData (bdata),
    .ongoingBroadcast         (ongoing),
    .dispatchError            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] id, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tg);
    dispatch = 1;
    eid = id;
    op1 = a;
    op2 = b;
    etag = tg;
  endtask

  logic [31:0] dexp [5];
  int c;
  logic seen;

  initial begin
    vt[0] = '{4'd0, 32'd5, 32'd7, 4'd3, 32'd12, 2};
    vt[1] = '{4'd1, 32'd10, 32'd3, 4'd1, 32'd7, 2};
    vt[2] = '{4'd1, 32'd3, 32'd5, 4'd2, 32'hFFFF_FFFE, 2};
    vt[3] = '{4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd4,
              32'h00F0_000F, 2};
    vt[4] = '{4'd3, 32'h1200_0034, 32'h0034_1200, 4'd5,
              32'h1234_1234, 2};
    vt[5] = '{4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd6,
              32'hF0F0_0F0F, 2};
    vt[6] = '{4'd5, 32'd1, 32'h23, 4'd7, 32'd8, 2};
    vt[7] = '{4'd6, 32'h8000_0000, 32'd31, 4'd8, 32'd1, 2};
    vt[8] = '{4'd7, 32'd6, 32'd7, 4'd9, 32'd42, 5};
    vt[9] = '{4'd7, 32'hFFFF_FFFF, 32'd2, 4'd10,
              32'hFFFF_FFFE, 5};

    #1;
    chk("rst_avail", 32'(avail), 32'h00FF);
    chk("rst_bda", 32'(bda), 0);
    chk("rst_err", 32'(err), 0);
    repeat (2) tick();
    rst = 0;
    #1;
    chk("idle_avail", 32'(avail), 32'h00FF);
    chk("idle_bda", 32'(bda), 0);
    chk("idle_tag", 32'(btag), 0);

    for (int k = 0; k < 10; k++) begin
      drive(vt[k].id, vt[k].a, vt[k].b, vt[k].tag);
      #1;
      chk($sformatf("v%0d_c0_avail", k), 32'(avail[vt[k].id]), 0);
      tick();
      dispatch = 0;
      #1;
      c = 1;
      while (!bda && c < 20) begin
        chk($sformatf("v%0d_busy", k), 32'(avail[vt[k].id]), 0);
        tick();
        c++;
      end
      chk($sformatf("v%0d_lat", k), 32'(c), 32'(vt[k].lat));
      chk($sformatf("v%0d_tag", k), 32'(btag), 32'(vt[k].tag));
      chk($sformatf("v%0d_data", k), bdata, vt[k].exp);
      chk($sformatf("v%0d_free", k), 32'(avail[vt[k].id]), 1);
      tick();
      chk($sformatf("v%0d_popped", k), 32'(bda), 0);
    end

    ongoing = 1;
    drive(4'd0, 32'd1, 32'd1, 4'd1);
    tick();
    drive(4'd1, 32'd5, 32'd1, 4'd2);
    tick();
    dispatch = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_tag", k), 32'(btag), 1);
      chk($sformatf("hold%0d_data", k), bdata, 2);
      tick();
    end
    ongoing = 0;
    #1;
    chk("rel_tag", 32'(btag), 1);
    tick();
    chk("next_bda", 32'(bda), 1);
    chk("next_tag", 32'(btag), 2);
    chk("next_data", bdata, 4);
    tick();
    chk("hold_empty", 32'(bda), 0);

    ongoing = 1;
    dexp[0] = 3;
    dexp[1] = 5;
    dexp[2] = 2;
    dexp[3] = 9;
    dexp[4] = 6;
    drive(4'd0, 32'd1, 32'd2, 4'd1);
    tick();
    drive(4'd1, 32'd9, 32'd4, 4'd2);
    tick();
    drive(4'd2, 32'd6, 32'd3, 4'd3);
    tick();
    drive(4'd3, 32'd8, 32'd1, 4'd4);
    tick();
    drive(4'd4, 32'd5, 32'd3, 4'd5);
    tick();
    dispatch = 0;
    tick();
    chk("full_xor_busy", 32'(avail[4]), 0);
    tick();
    chk("full_xor_busy2", 32'(avail[4]), 0);
    chk("full_add_free", 32'(avail[0]), 1);
    chk("full_head", 32'(btag), 1);
    ongoing = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain%0d_bda", k), 32'(bda), 1);
      chk($sformatf("drain%0d_tag", k), 32'(btag), 32'(k + 1));
      chk($sformatf("drain%0d_data", k), bdata, dexp[k]);
      tick();
    end
    chk("drain_empty", 32'(bda), 0);
    chk("drain_avail", 32'(avail), 32'h00FF);

    chk("err_clean", 32'(err), 0);
    drive(4'd10, 32'd1, 32'd1, 4'd1);
    #1;
    chk("unimpl_avail", 32'(avail[10]), 0);
    tick();
    dispatch = 0;
    #1;
    chk("err_unimpl", 32'(err), 1);
    chk("unimpl_nobcast", 32'(bda), 0);
    drive(4'd7, 32'd3, 32'd3, 4'd2);
    tick();
    drive(4'd7, 32'd4, 32'd4, 4'd3);
    tick();
    dispatch = 0;
    #1;
    chk("err_sticky", 32'(err), 1);
    chk("mul_busy", 32'(avail[7]), 0);
    tick();
    rst = 1;
    #1;
    chk("arst_avail", 32'(avail), 32'h00FF);
    chk("arst_bda", 32'(bda), 0);
    chk("arst_err", 32'(err), 0);
    tick();
    rst = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | bda;
    end
    chk("post_rst_nobcast", 32'(seen), 0);
    chk("post_rst_avail", 32'(avail), 32'h00FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
